dla_rand_arbiter: RTL and testbench

Shares one LFSR random-number generator among N random-walk particle engines in the diffusion-limited-aggregation datapath. Requesters ask for a uniformly distributed value in [0, max]. The block arbitrates round-robin and advances the LFSR only while drawing. It rejection-samples against a power-of-two mask and returns the value with a one-cycle ack pulse.

---
 rtl/dla_pkg.sv | 23 ++
 rtl/dla_lsfr.sv | 36 +++
 rtl/dla_rand_arbiter.sv | 151 +++++++++++++++
 tb/tb_dla_rand_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_pkg.sv
// Shared types and constants for the DLA random-number arbiter.
package dla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [15:0] DEF_TAP  = 16'hD008;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    // Smallest 2^k-1 covering v: smear every set bit down to bit 0.
    function automatic logic [63:0] smear_mask(input logic [63:0] v);
        logic [63:0] m;
        m = v;
        for (int s = 1; s < 64; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

endpackage

// File: rtl/dla_lsfr.sv
// Galois-style shift-left LFSR that advances only when asked to.
module dla_lsfr
    import dla_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAP   = WIDTH'(DEF_TAP),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    // Next value: msb wraps into bit 0 and is xored into every tapped bit.
    always_comb begin
        lfsr_d = lfsr_q;
        if (shift) begin
            lfsr_d[0] = lfsr_q[WIDTH-1];
            for (int i = 1; i < WIDTH; i++) begin
                lfsr_d[i] = lfsr_q[i-1] ^ (TAP[i] & lfsr_q[WIDTH-1]);
            end
        end
    end

    // State register; reset reloads the seed so sequences are reproducible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/dla_rand_arbiter.sv
// Round-robin arbiter handing out bounded uniform random values from one
// shared LFSR, using mask-and-reject sampling with a bounded retry count.
module dla_rand_arbiter
    import dla_pkg::*;
#(
    parameter int               N          = 4,
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAP        = WIDTH'(DEF_TAP),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEF_SEED),
    parameter int               MAX_TRY    = 8,
    parameter bit               IDLE_SHIFT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_max,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic                 busy
);

    localparam int IDW = $clog2(N);
    localparam int TW  = $clog2(MAX_TRY + 1);

    state_e           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             busy_q, busy_d;

    logic             lfsr_shift;
    logic [WIDTH-1:0] lfsr_val;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] pick_max;
    logic [IDW-1:0]   pick;
    logic             found;

    dla_lsfr #(
        .WIDTH (WIDTH),
        .TAP   (TAP),
        .SEED  (SEED)
    ) u_lsfr (
        .clk   (clk),
        .rst   (rst),
        .shift (lfsr_shift),
        .value (lfsr_val)
    );

    // Round-robin pick: first active request after the last one served.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int j = 1; j <= N; j++) begin
            if (!found && req[(int'(last_q) + j) % N]) begin
                found = 1'b1;
                pick  = IDW'((int'(last_q) + j) % N);
            end
        end
    end

    assign pick_max = req_max[int'(pick)*WIDTH +: WIDTH];
    assign cand     = lfsr_val & mask_q;

    // FSM next state: grant in IDLE, draw/reject in DRAW, one-cycle ack in RESP.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        last_d     = last_q;
        max_d      = max_q;
        mask_d     = mask_q;
        tries_d    = tries_q;
        ack_d      = '0;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        lfsr_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                lfsr_shift = IDLE_SHIFT;
                if (found) begin
                    id_d    = pick;
                    max_d   = pick_max;
                    mask_d  = WIDTH'(smear_mask(64'(pick_max)));
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                lfsr_shift = 1'b1;
                if (cand <= max_q) begin
                    rsp_data_d = cand;
                    rsp_id_d   = id_q;
                    ack_d      = N'(1) << id_q;
                    state_d    = RESP;
                end else if (tries_q == TW'(MAX_TRY - 1)) begin
                    // mask < 2*max+1, so halving the rejected value lands in range
                    rsp_data_d = cand >> 1;
                    rsp_id_d   = id_q;
                    ack_d      = N'(1) << id_q;
                    state_d    = RESP;
                end else begin
                    tries_d = tries_q + TW'(1);
                end
            end
            RESP: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            last_q     <= IDW'(N - 1);
            max_q      <= '0;
            mask_q     <= '0;
            tries_q    <= '0;
            ack_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            last_q     <= last_d;
            max_q      <= max_d;
            mask_q     <= mask_d;
            tries_q    <= tries_d;
            ack_q      <= ack_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dla_rand_arbiter.sv
// Bench for dla_rand_arbiter: three configurations (default, MAX_TRY=2,
// IDLE_SHIFT=1) checked every cycle against a transaction-level model.
module tb_dla_rand_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0][N-1:0] req_v;
    logic [N*W-1:0]    req_max;
    logic [2:0][N-1:0] ack_v;
    logic [2:0][W-1:0] data_v;
    logic [2:0][1:0]   id_v;
    logic [2:0]        busy_v;

    always #5 clk = ~clk;

    dla_rand_arbiter #(.N(N), .WIDTH(W), .TAP(16'hD008), .SEED(16'hFFFF), .MAX_TRY(8), .IDLE_SHIFT(1'b0)) u0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .req_max(req_max),
        .ack(ack_v[0]), .rsp_data(data_v[0]), .rsp_id(id_v[0]), .busy(busy_v[0]));
    dla_rand_arbiter #(.N(N), .WIDTH(W), .TAP(16'hD008), .SEED(16'hFFFF), .MAX_TRY(2), .IDLE_SHIFT(1'b0)) u1 (
        .clk(clk), .rst(rst), .req(req_v[1]), .req_max(req_max),
        .ack(ack_v[1]), .rsp_data(data_v[1]), .rsp_id(id_v[1]), .busy(busy_v[1]));
    dla_rand_arbiter #(.N(N), .WIDTH(W), .TAP(16'hD008), .SEED(16'hFFFF), .MAX_TRY(8), .IDLE_SHIFT(1'b1)) u2 (
        .clk(clk), .rst(rst), .req(req_v[2]), .req_max(req_max),
        .ack(ack_v[2]), .rsp_data(data_v[2]), .rsp_id(id_v[2]), .busy(busy_v[2]));

    // ---------------- reference model ----------------
    function automatic int mt(input int k);
        return (k == 1) ? 2 : 8;
    endfunction

    function automatic logic [15:0] step(input logic [15:0] s);
        logic [15:0] n;
        n = (s << 1) | {15'd0, s[15]};
        if (s[15]) n = n ^ (16'hD008 & 16'hFFFE);
        return n;
    endfunction

    // Whole transaction at once: returns the value, draw count, and final LFSR.
    task automatic draw(input logic [15:0] lf, input logic [15:0] mx, input int tries,
                        output logic [15:0] data, output int d, output logic [15:0] lf_out);
        logic [15:0] mask, c;
        mask = 16'h0;
        while (mask < mx) mask = {mask[14:0], 1'b1};
        d = 0;
        data = 16'h0;
        for (int t = 0; t < tries; t++) begin
            c  = lf & mask;
            lf = step(lf);
            d  = t + 1;
            if (c <= mx) begin
                data = c;
                break;
            end
            if (t == tries - 1) data = c >> 1;
        end
        lf_out = lf;
    endtask

    // m_rem: cycles left in the transaction (1 = ack cycle, 0 = idle)
    int          m_rem  [3];
    int          m_id   [3];
    int          m_last [3];
    logic [15:0] m_lfsr [3];
    logic [15:0] m_data [3];
    int          mw, md;
    logic [15:0] mnl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_rem[k] = 0; m_id[k] = 0; m_last[k] = N - 1; m_lfsr[k] = 16'hFFFF; m_data[k] = 16'h0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_rem[k] == 0) begin
                    if (k == 2) m_lfsr[k] = step(m_lfsr[k]);
                    if (req_v[k] != 0) begin
                        mw = -1;
                        for (int j = 1; j <= N; j++)
                            if (mw < 0 && req_v[k][(m_last[k] + j) % N]) mw = (m_last[k] + j) % N;
                        m_id[k] = mw;
                        m_last[k] = mw;
                        draw(m_lfsr[k], req_max[mw*W +: W], mt(k), m_data[k], md, mnl);
                        m_lfsr[k] = mnl;
                        m_rem[k] = md + 1;
                    end
                end else begin
                    m_rem[k] = m_rem[k] - 1;
                end
            end
        end
    end

    // ---------------- checking / driving ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0;
    bit          got      [3];
    logic [15:0] got_data [3];
    int          got_id   [3];
    int          got_cyc  [3];
    int          order[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle: compare all DUTs with the model, log acks, drop acked requests.
    task automatic tick();
        logic [N-1:0] ea;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                ea = (m_rem[k] == 1) ? (N'(1) << m_id[k]) : '0;
                chk($sformatf("ack%0d", k), 32'(ack_v[k]), 32'(ea));
                chk($sformatf("busy%0d", k), 32'(busy_v[k]), 32'(m_rem[k] != 0));
                chk($sformatf("onehot%0d", k), 32'($onehot0(ack_v[k])), 32'd1);
                if (ea != 0) begin
                    chk($sformatf("data%0d", k), 32'(data_v[k]), 32'(m_data[k]));
                    chk($sformatf("id%0d", k), 32'(id_v[k]), 32'(m_id[k]));
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (ack_v[k] != 0) begin
                got[k] = 1'b1; got_data[k] = data_v[k]; got_id[k] = int'(id_v[k]); got_cyc[k] = cyc;
                if (k == 0) order.push_back(int'(id_v[k]));
                req_v[k] = req_v[k] & ~ack_v[k];
            end
        end
    endtask

    task automatic clear_got();
        for (int k = 0; k < 3; k++) got[k] = 1'b0;
    endtask

    task automatic req_all(input int i, input logic [15:0] mx);
        req_max[i*W +: W] = mx;
        for (int k = 0; k < 3; k++) req_v[k][i] = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_ack(input int k);
        int n = 0;
        while (!got[k] && n < 30) begin tick(); n++; end
        chk($sformatf("ack_seen%0d", k), 32'(got[k]), 32'd1);
    endtask

    task automatic settle();
        int n = 0;
        while ((busy_v != 0 || req_v != 0) && n < 60) begin tick(); n++; end
        chk("settle", 32'(busy_v != 0 || req_v != 0), 32'd0);
        tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    logic [15:0] seq_exp [5] = '{16'hFFFF, 16'h2FF7, 16'h5FEE, 16'hBFDC, 16'hAFB1};
    bit reraised;

    initial begin
        req_v = '0;
        req_max = '0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", 32'(ack_v[k]), 0);
            chk("rst_data", 32'(data_v[k]), 0);
            chk("rst_id", 32'(id_v[k]), 0);
            chk("rst_busy", 32'(busy_v[k]), 0);
        end
        rst = 1'b0;
        tick();

        // raw LFSR sequence with max = all-ones
        for (int s = 0; s < 5; s++) begin
            clear_got();
            req_all(0, 16'hFFFF);
            wait_ack(0);
            chk("seq_data", 32'(got_data[0]), 32'(seq_exp[s]));
            chk("seq_lat", 32'(got_cyc[0] - t0), 32'd2);
            settle();
        end

        // rejection (MAX_TRY=8) and fallback (MAX_TRY=2) from a fresh seed
        pulse_rst();
        clear_got();
        req_all(2, 16'h0004);
        wait_ack(0);
        wait_ack(1);
        chk("rej_data", 32'(got_data[0]), 32'h4);
        chk("rej_id", 32'(got_id[0]), 32'd2);
        chk("rej_lat", 32'(got_cyc[0] - t0), 32'd5);
        chk("fb_data", 32'(got_data[1]), 32'h3);
        chk("fb_lat", 32'(got_cyc[1] - t0), 32'd3);
        settle();

        // max = 0 accepts on first draw
        clear_got();
        req_all(1, 16'h0000);
        wait_ack(0);
        chk("max0_data", 32'(got_data[0]), 32'h0);
        chk("max0_lat", 32'(got_cyc[0] - t0), 32'd2);
        settle();

        // reset during DRAW aborts; held request then restarts from the seed
        pulse_rst();
        clear_got();
        req_all(0, 16'hFFFF);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy_v[0]), 0);
        chk("abort_ack", 32'(ack_v[0]), 0);
        tick();
        rst = 1'b0;
        chk("abort_no_ack", 32'(got[0]), 0);
        t0 = cyc;
        wait_ack(0);
        chk("reseed_data", 32'(got_data[0]), 32'hFFFF);
        chk("reseed_lat", 32'(got_cyc[0] - t0), 32'd2);
        settle();

        // request dropped after grant still completes
        clear_got();
        req_all(1, 16'h0009);
        tick();
        for (int k = 0; k < 3; k++) req_v[k][1] = 1'b0;
        wait_ack(0);
        chk("drop_id", 32'(got_id[0]), 32'd1);
        settle();

        // round robin: 1011 held, bit 0 re-raised after its ack -> 0,1,3,0
        pulse_rst();
        order.delete();
        req_max = {N{16'hFFFF}};
        for (int k = 0; k < 3; k++) req_v[k] = 4'b1011;
        reraised = 1'b0;
        for (int n = 0; n < 60 && order.size() < 4; n++) begin
            tick();
            if (order.size() == 1 && !reraised && ack_v[0] == 0) begin
                reraised = 1'b1;
                for (int k = 0; k < 3; k++) req_v[k][0] = 1'b1;
            end
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            chk("rr_0", 32'(order[0]), 0);
            chk("rr_1", 32'(order[1]), 1);
            chk("rr_2", 32'(order[2]), 3);
            chk("rr_3", 32'(order[3]), 0);
        end
        settle();

        // randomized traffic, occasional asynchronous reset
        repeat (4000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) begin
                    case ($urandom_range(3))
                        0: req_max[i*W +: W] = 16'h0000;
                        1: req_max[i*W +: W] = 16'hFFFF;
                        2: req_max[i*W +: W] = 16'($urandom_range(15));
                        default: req_max[i*W +: W] = 16'($urandom);
                    endcase
                end
                for (int k = 0; k < 3; k++) begin
                    if (!req_v[k][i] && !ack_v[k][i] && $urandom_range(3) == 0) req_v[k][i] = 1'b1;
                    else if (req_v[k][i] && $urandom_range(31) == 0) req_v[k][i] = 1'b0;
                end
            end
            if ($urandom_range(799) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end
        req_v = '0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
